// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_if
// Purpose  : Bus bundle between result producers and the regfile write port.
// Revision : 1.0
// ============================================================================
interface wb_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] pending;
  logic        stall_req;

  // Producer side: pipeline, long-latency unit and hazard-unit observer
  modport master (
    output pipe_we, pipe_rd, pipe_data,
    output lu_valid, lu_rd, lu_data, lu_issue, lu_issue_rd,
    input  lu_ready, we3, a3, wd3, pending, stall_req
  );

  // Arbiter side
  modport slave (
    input  pipe_we, pipe_rd, pipe_data,
    input  lu_valid, lu_rd, lu_data, lu_issue, lu_issue_rd,
    output lu_ready, we3, a3, wd3, pending, stall_req
  );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Merges pipeline writeback and buffered long-latency results onto
//            the regfile write port, with pending scoreboard and stall request.
// Option   : WB_BYPASS_EN - LU result skips an empty FIFO when the slot is free.
// Revision : 1.0
// ============================================================================
module wb_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   C_FULL   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] C_STARVE = CW'(STARVE_MAX);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // FIFO storage and pointers
  logic [4:0]    rd_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  // Write port and scoreboard
  logic          we3_q, we3_d;
  logic [4:0]    a3_q,  a3_d;
  logic [31:0]   wd3_q, wd3_d;
  logic [31:0]   pending_q, pending_d;

  // Starvation tracking
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_q, stall_d;

  logic          w_empty;
  logic          w_full;
  logic          w_lu_ready;
  logic          w_accept;
  logic          w_pipe_win;
  logic          w_pop;
  logic          w_push;
  logic          w_bypass;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;
  logic [31:0]   w_set;
  logic [31:0]   w_clr;

  assign w_empty     = (count_q == '0);
  assign w_full      = (count_q == C_FULL);
  assign w_lu_ready  = !reset && !w_full;
  assign w_accept    = bus.lu_valid && w_lu_ready;
  assign w_pipe_win  = bus.pipe_we && (bus.pipe_rd != 5'd0);
  assign w_pop       = !w_pipe_win && !w_empty;
  assign w_head_rd   = rd_mem_q[rd_ptr_q];
  assign w_head_data = data_mem_q[rd_ptr_q];

`ifdef WB_BYPASS_EN
  assign w_bypass = w_accept && (bus.lu_rd != 5'd0) && w_empty && !w_pipe_win;
`else
  assign w_bypass = 1'b0;
`endif

  // rd=0 results are acknowledged but never stored
  assign w_push = w_accept && (bus.lu_rd != 5'd0) && !w_bypass;

  // --------------------------------------------------------------------------
  // FIFO bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      rd_mem_q[wr_ptr_q]   <= bus.lu_rd;
      data_mem_q[wr_ptr_q] <= bus.lu_data;
    end
  end

  // --------------------------------------------------------------------------
  // Write-slot arbitration and scoreboard
  // --------------------------------------------------------------------------
  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    w_clr = '0;
    if (w_pipe_win) begin
      we3_d = 1'b1;
      a3_d  = bus.pipe_rd;
      wd3_d = bus.pipe_data;
    end else if (w_pop) begin
      we3_d            = 1'b1;
      a3_d             = w_head_rd;
      wd3_d            = w_head_data;
      w_clr[w_head_rd] = 1'b1;
    end else if (w_bypass) begin
      we3_d            = 1'b1;
      a3_d             = bus.lu_rd;
      wd3_d            = bus.lu_data;
      w_clr[bus.lu_rd] = 1'b1;
    end
  end

  // A new issue on the commit edge of the same register keeps it pending
  always_comb begin
    w_set = '0;
    if (bus.lu_issue && (bus.lu_issue_rd != 5'd0)) begin
      w_set[bus.lu_issue_rd] = 1'b1;
    end
    pending_d = (pending_q & ~w_clr) | w_set;
  end

  // --------------------------------------------------------------------------
  // Starvation FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    case (state_q)
      ST_RUN: begin
        if (w_empty || w_pop) begin
          cnt_d = '0;
        end else if (cnt_q == C_STARVE - 1'b1) begin
          cnt_d   = C_STARVE;
          state_d = ST_STALL;
          stall_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STALL: begin
        if (w_empty) begin
          state_d = ST_RUN;
          stall_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        stall_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      we3_q     <= 1'b0;
      a3_q      <= 5'd0;
      wd3_q     <= 32'd0;
      pending_q <= 32'd0;
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      stall_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      we3_q     <= we3_d;
      a3_q      <= a3_d;
      wd3_q     <= wd3_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.lu_ready  = w_lu_ready;
  assign bus.we3       = we3_q;
  assign bus.a3        = a3_q;
  assign bus.wd3       = wd3_q;
  assign bus.pending   = pending_q;
  assign bus.stall_req = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Directed and randomized checks of wb_arbiter against a queue model.
// Revision : 1.0
// ============================================================================
module tb_wb_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic reset;
  wb_arbiter_if bus ();

  wb_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [4:0]  mq_rd[$];
  logic [31:0] mq_data[$];
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_a;
  logic [31:0] m_wd;
  logic        m_stall;
  int          m_cnt;
  logic [4:0]  iss_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_rd.delete();
    mq_data.delete();
    iss_q.delete();
    m_pend  = '0;
    m_we    = 1'b0;
    m_a     = '0;
    m_wd    = '0;
    m_stall = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic set_idle();
    bus.pipe_we     = 1'b0;
    bus.pipe_rd     = '0;
    bus.pipe_data   = '0;
    bus.lu_valid    = 1'b0;
    bus.lu_rd       = '0;
    bus.lu_data     = '0;
    bus.lu_issue    = 1'b0;
    bus.lu_issue_rd = '0;
  endtask

  // Called just after a rising edge with inputs applied; advances one cycle.
  task automatic step(output logic acc);
    logic        ready, pw_win, was_empty, popped, bypassed;
    logic [31:0] clr, setm;
    #2;
    ready = (mq_rd.size() < DEPTH);
    check_eq("lu_ready", bus.lu_ready, ready);
    acc       = bus.lu_valid && ready;
    pw_win    = bus.pipe_we && (bus.pipe_rd != 0);
    was_empty = (mq_rd.size() == 0);
    popped    = 1'b0;
    bypassed  = 1'b0;
    clr       = '0;
    setm      = '0;
    if (bus.lu_issue && bus.lu_issue_rd != 0) setm[bus.lu_issue_rd] = 1'b1;
    if (pw_win) begin
      m_we = 1'b1; m_a = bus.pipe_rd; m_wd = bus.pipe_data;
    end else if (!was_empty) begin
      m_we = 1'b1; m_a = mq_rd.pop_front(); m_wd = mq_data.pop_front();
      popped = 1'b1; clr[m_a] = 1'b1;
    end
`ifdef WB_BYPASS_EN
    else if (acc && bus.lu_rd != 0) begin
      m_we = 1'b1; m_a = bus.lu_rd; m_wd = bus.lu_data;
      bypassed = 1'b1; clr[m_a] = 1'b1;
    end
`endif
    else begin
      m_we = 1'b0;
    end
    if (acc && bus.lu_rd != 0 && !bypassed) begin
      mq_rd.push_back(bus.lu_rd);
      mq_data.push_back(bus.lu_data);
    end
    m_pend = (m_pend & ~clr) | setm;
    if (!m_stall) begin
      if (was_empty || popped) m_cnt = 0;
      else begin
        m_cnt++;
        if (m_cnt >= STARVE_MAX) m_stall = 1'b1;
      end
    end else if (was_empty) begin
      m_stall = 1'b0;
      m_cnt   = 0;
    end
    @(posedge clk);
    #1;
    check_eq("we3", bus.we3, m_we);
    check_eq("a3", bus.a3, m_a);
    check_eq("wd3", bus.wd3, m_wd);
    check_eq("pending", bus.pending, m_pend);
    check_eq("stall_req", bus.stall_req, m_stall);
  endtask

  task automatic issue(input logic [4:0] rd);
    logic acc;
    bus.lu_issue    = 1'b1;
    bus.lu_issue_rd = rd;
    step(acc);
    bus.lu_issue    = 1'b0;
  endtask

  // Pipeline hogs the slot while LU pushes r0, r1 and then holds r2 until stall.
  task automatic fill_and_stall(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    logic [4:0] seq [3];
    int         idx;
    logic       acc;
    seq[0] = r0; seq[1] = r1; seq[2] = r2;
    idx = 0;
    issue(r0);
    issue(r1);
    bus.pipe_we  = 1'b1;
    bus.pipe_rd  = 5'd3;
    bus.lu_valid = 1'b1;
    bus.lu_rd    = seq[0];
    bus.lu_data  = 32'hA000_0000 | 32'(seq[0]);
    for (int c = 0; c < 16; c++) begin
      bus.pipe_data = $urandom;
      step(acc);
      if (acc && idx < 2) begin
        idx++;
        bus.lu_rd   = seq[idx];
        bus.lu_data = 32'hA000_0000 | 32'(seq[idx]);
      end
      if (bus.stall_req) break;
    end
    check_eq("fill_stall", bus.stall_req, 1);
    check_eq("fill_ready", bus.lu_ready, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc;
    int         lat;
    int         pct;
    logic [4:0] rd;

    reset = 1'b1;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_we3", bus.we3, 0);
    check_eq("rst_a3", bus.a3, 0);
    check_eq("rst_wd3", bus.wd3, 0);
    check_eq("rst_pending", bus.pending, 0);
    check_eq("rst_stall", bus.stall_req, 0);
    check_eq("rst_ready", bus.lu_ready, 0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_ready", bus.lu_ready, 1);

    // Pipeline only
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_data = 32'hDEADBEEF;
    step(acc);
    check_eq("pipe_we3", bus.we3, 1);
    check_eq("pipe_a3", bus.a3, 5);
    check_eq("pipe_wd3", bus.wd3, 32'hDEADBEEF);
    bus.pipe_rd = 5'd0; bus.pipe_data = 32'h1111_2222;
    step(acc);
    check_eq("pipe_rd0_we3", bus.we3, 0);
    bus.pipe_we = 1'b0;

    // LU only
    issue(5'd7);
    check_eq("lu_pend7_set", bus.pending[7], 1);
    step(acc);
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 32'h12345678;
    step(acc);
    bus.lu_valid = 1'b0;
    lat = 1;
    while (!bus.we3 && lat < 5) begin
      step(acc);
      lat++;
    end
`ifdef WB_BYPASS_EN
    check_eq("lu_latency", lat, 1);
`else
    check_eq("lu_latency", lat, 2);
`endif
    check_eq("lu_a3", bus.a3, 7);
    check_eq("lu_wd3", bus.wd3, 32'h12345678);
    check_eq("lu_pend7_clr", bus.pending[7], 0);

    // Collision, starvation and full-boundary pop
    fill_and_stall(5'd9, 5'd10, 5'd11);
    bus.pipe_we = 1'b0;
    #1;
    check_eq("full_ready", bus.lu_ready, 0);
    step(acc);
    check_eq("drain_a3_9", bus.a3, 9);
    step(acc);
    check_eq("drain_a3_10", bus.a3, 10);
    bus.lu_valid = 1'b0;
    step(acc);
    check_eq("drain_a3_11", bus.a3, 11);
    step(acc);
    step(acc);
    check_eq("drain_stall", bus.stall_req, 0);

    // Commit of x4 on the same edge as a new issue to x4
    issue(5'd4);
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd2; bus.pipe_data = 32'h0000_0002;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd4; bus.lu_data = 32'h4444_4444;
    step(acc);
    set_idle();
    bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd4;
    step(acc);
    bus.lu_issue = 1'b0;
    check_eq("race_a3", bus.a3, 4);
    check_eq("race_pend4", bus.pending[4], 1);

    // Reset while stalled with a full FIFO
    fill_and_stall(5'd12, 5'd13, 5'd14);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mrst_we3", bus.we3, 0);
    check_eq("mrst_pending", bus.pending, 0);
    check_eq("mrst_stall", bus.stall_req, 0);
    check_eq("mrst_ready", bus.lu_ready, 0);
    model_reset();
    set_idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("mrst_release_ready", bus.lu_ready, 1);

    // Randomized traffic at increasing pipeline pressure
    for (int ph = 0; ph < 3; ph++) begin
      pct = (ph == 0) ? 20 : (ph == 1) ? 60 : 95;
      for (int c = 0; c < 300; c++) begin
        bus.pipe_we   = ($urandom_range(0, 99) < pct);
        bus.pipe_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.pipe_data = $urandom;
        if (!bus.lu_valid) begin
          if (iss_q.size() != 0 && $urandom_range(0, 2) == 0) begin
            bus.lu_valid = 1'b1;
            bus.lu_rd    = iss_q.pop_front();
            bus.lu_data  = $urandom;
          end else if ($urandom_range(0, 19) == 0) begin
            bus.lu_valid = 1'b1;
            bus.lu_rd    = 5'd0;
            bus.lu_data  = $urandom;
          end
        end
        rd = 5'($urandom_range(1, 31));
        bus.lu_issue    = 1'b0;
        bus.lu_issue_rd = rd;
        if ($urandom_range(0, 2) == 0 && !m_pend[rd]) begin
          bus.lu_issue = 1'b1;
          iss_q.push_back(rd);
        end
        step(acc);
        if (acc) bus.lu_valid = 1'b0;
      end
    end

    set_idle();
    repeat (6) step(acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
